// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the radix-2 DIT FFT address generator:
//   - state_e   : one-hot controller states (IDLE, BITREV, PROC, DONE)
//   - LOG2N_MIN / LOG2N_MAX : legal range of the log2 transform size
//   - PASS_W    : width of pass / size fields (enough to hold LOG2N_MAX)
//   - clampLog2Size : maps an out-of-range runtime size onto the maximum
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N_MIN = 2;
    localparam int LOG2N_MAX = 12;
    localparam int PASS_W    = $clog2(LOG2N_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_BITREV = 4'b0010,
        ST_PROC   = 4'b0100,
        ST_DONE   = 4'b1000
    } state_e;

    // A requested size below the smallest legal transform or above the
    // instance maximum falls back to the instance maximum.
    function automatic logic [PASS_W-1:0] clampLog2Size(
        input logic [PASS_W-1:0] req,
        input int                maxLog2
    );
        logic [PASS_W-1:0] maxV;
        maxV = PASS_W'(maxLog2);
        if ((req < PASS_W'(LOG2N_MIN)) || (req > maxV)) begin
            return maxV;
        end
        return req;
    endfunction

endpackage

// File: rtl/fft_bitrev.sv
// ---------------------------------------------------------------------------
// fft_bitrev
//
// Combinational bit reverser with a runtime width.  Only the low width_i
// bits of n_i are reversed; the result is right-aligned.
//
// Ports:
//   n_i     in  LOG2N   : natural index (bits at or above width_i are zero)
//   width_i in  PASS_W  : number of bits to reverse (1..LOG2N)
//   r_o     out LOG2N   : reverse(n_i[width_i-1:0])
// ---------------------------------------------------------------------------
module fft_bitrev
    import fft_pkg::*;
#(
    parameter int LOG2N = 8
) (
    input  logic [LOG2N-1:0]  n_i,
    input  logic [PASS_W-1:0] width_i,
    output logic [LOG2N-1:0]  r_o
);

    logic [LOG2N-1:0]  revFull;
    logic [PASS_W-1:0] shiftAmt;

    // Reverse across the full LOG2N bits, then shift the result down so the
    // reversal is effectively over width_i bits.
    for (genvar b = 0; b < LOG2N; b++) begin : gRev
        assign revFull[b] = n_i[LOG2N-1-b];
    end

    assign shiftAmt = PASS_W'(LOG2N) - width_i;
    assign r_o      = revFull >> shiftAmt;

endmodule

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
//
// Radix-2 DIT FFT address generator.  Sweeps pass / block / butterfly
// counters for a runtime transform size 2^s (s <= LOG2N) and, per
// butterfly, presents the top and bottom data-RAM indices plus an address
// into a shared N/2-entry twiddle ROM.  Outputs are handed over with a
// valid/ready handshake so the datapath can stall the sweep.
//
// Optional feature macro: FFT_BITREV_EN
//   defined   : a BITREV pass precedes the butterflies and emits each
//               bit-reversal swap pair (n, reverse(n)) exactly once.
//   undefined : IDLE goes straight to PROC, bitrev_phase is tied low.
//
// Ports:
//   Clk          in  1       : clock, rising edge
//   Reset        in  1       : synchronous active-high reset
//   Start        in  1       : begin a transform (taken in IDLE only)
//   Log2Size     in  4       : runtime log2 size, latched on Start
//   Ack          in  1       : return from DONE to IDLE
//   out_ready    in  1       : datapath accepts the current tuple
//   out_valid    out 1       : tuple on i_top/i_bot/twiddle is valid
//   i_top        out LOG2N   : top index (natural index in BITREV)
//   i_bot        out LOG2N   : bottom index (reversed index in BITREV)
//   twiddle      out LOG2N-1 : twiddle ROM address (0 in BITREV)
//   pass         out 4       : current butterfly pass
//   bitrev_phase out 1       : high while in BITREV
//   last         out 1       : high with the final transfer
//   Done         out 1       : high in DONE
//   state        out 4       : one-hot state
// ---------------------------------------------------------------------------
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Log2Size,
    input  logic             Ack,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [LOG2N-1:0] i_top,
    output logic [LOG2N-1:0] i_bot,
    output logic [LOG2N-2:0] twiddle,
    output logic [3:0]       pass,
    output logic             bitrev_phase,
    output logic             last,
    output logic             Done,
    output logic [3:0]       state
);

    localparam int         W   = LOG2N + 1;
    localparam logic [W-1:0] ONE = W'(1);

    state_e            state_q, state_d;
    logic [PASS_W-1:0] size_q,  size_d;
    logic [PASS_W-1:0] pass_q,  pass_d;
    logic [W-1:0]      blk_q,   blk_d;
    logic [W-1:0]      bfly_q,  bfly_d;

    logic [W-1:0]      kMax;
    logic [W-1:0]      jMax;
    logic [PASS_W-1:0] jShift;
    logic [PASS_W-1:0] twShift;
    logic [LOG2N-1:0]  topIdx;
    logic [LOG2N-1:0]  botIdx;
    logic [LOG2N-2:0]  twAddr;
    logic              lastPass;
    logic              procLast;

    // Butterfly addressing for pass i, block j, butterfly k:
    //   top = (j << (i+1)) + k, bot = top + 2^i, twiddle = k << (LOG2N-1-i).
    // The twiddle shift is relative to the maximum size so one ROM serves
    // every runtime size.  Sums are formed W bits wide, then truncated.
    always_comb begin
        kMax     = (ONE << pass_q) - ONE;
        jShift   = size_q - pass_q - PASS_W'(1);
        jMax     = (ONE << jShift) - ONE;
        twShift  = PASS_W'(LOG2N - 1) - pass_q;
        topIdx   = LOG2N'((blk_q << (pass_q + PASS_W'(1))) + bfly_q);
        botIdx   = LOG2N'((blk_q << (pass_q + PASS_W'(1))) + bfly_q + (ONE << pass_q));
        twAddr   = (LOG2N-1)'(bfly_q << twShift);
        lastPass = (pass_q == (size_q - PASS_W'(1)));
        procLast = (bfly_q == kMax) && (blk_q == jMax) && lastPass;
    end

`ifdef FFT_BITREV_EN
    logic [LOG2N-1:0] nIdx_q, nIdx_d;
    logic [LOG2N-1:0] revIdx;
    logic             nLast;
    logic             brValid;

    fft_bitrev #(
        .LOG2N (LOG2N)
    ) uBitrev (
        .n_i     (nIdx_q),
        .width_i (size_q),
        .r_o     (revIdx)
    );

    // Only n < reverse(n) is emitted so each swap pair appears once;
    // palindromic and already-covered indices are skipped without a stall.
    always_comb begin
        nLast   = (nIdx_q == LOG2N'((ONE << size_q) - ONE));
        brValid = (nIdx_q < revIdx);
    end
`endif

    // Output decode: combinational from registered counters and state, so
    // the tuple holds while the datapath withholds out_ready.
    always_comb begin
        out_valid    = 1'b0;
        i_top        = topIdx;
        i_bot        = botIdx;
        twiddle      = twAddr;
        last         = 1'b0;
        Done         = 1'b0;
        bitrev_phase = 1'b0;
        case (state_q)
            ST_PROC: begin
                out_valid = 1'b1;
                last      = procLast;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
`ifdef FFT_BITREV_EN
            ST_BITREV: begin
                out_valid    = brValid;
                i_top        = nIdx_q;
                i_bot        = revIdx;
                twiddle      = '0;
                bitrev_phase = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign pass  = pass_q;
    assign state = state_q;

    // Next-state and counter sequencing.  Butterfly k is innermost, then
    // block j, then pass i; counters move only on an accepted transfer.
    // An unrecognised state encoding recovers to IDLE with cleared counters.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        pass_d  = pass_q;
        blk_d   = blk_q;
        bfly_d  = bfly_q;
`ifdef FFT_BITREV_EN
        nIdx_d  = nIdx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    size_d = clampLog2Size(Log2Size, LOG2N);
                    pass_d = '0;
                    blk_d  = '0;
                    bfly_d = '0;
`ifdef FFT_BITREV_EN
                    nIdx_d  = '0;
                    state_d = ST_BITREV;
`else
                    state_d = ST_PROC;
`endif
                end
            end
`ifdef FFT_BITREV_EN
            ST_BITREV: begin
                if (!brValid || out_ready) begin
                    if (nLast) begin
                        nIdx_d  = '0;
                        state_d = ST_PROC;
                    end else begin
                        nIdx_d = nIdx_q + LOG2N'(1);
                    end
                end
            end
`endif
            ST_PROC: begin
                if (out_ready) begin
                    if (bfly_q != kMax) begin
                        bfly_d = bfly_q + ONE;
                    end else begin
                        bfly_d = '0;
                        if (blk_q != jMax) begin
                            blk_d = blk_q + ONE;
                        end else begin
                            blk_d = '0;
                            if (!lastPass) begin
                                pass_d = pass_q + PASS_W'(1);
                            end else begin
                                pass_d  = '0;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pass_d  = '0;
                blk_d   = '0;
                bfly_d  = '0;
`ifdef FFT_BITREV_EN
                nIdx_d  = '0;
`endif
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            pass_q  <= '0;
            blk_q   <= '0;
            bfly_q  <= '0;
`ifdef FFT_BITREV_EN
            nIdx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            pass_q  <= pass_d;
            blk_q   <= blk_d;
            bfly_q  <= bfly_d;
`ifdef FFT_BITREV_EN
            nIdx_q  <= nIdx_d;
`endif
        end
    end

endmodule

// File: tb/tb_fft_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_fft_addr_gen
//
// Directed bench for fft_addr_gen with two instances: LOG2N=3 (full tuple
// tables, stall, mid-run reset) and LOG2N=8 (runtime size and clamping).
// ---------------------------------------------------------------------------
module tb_fft_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LOG2N = 3 instance
    logic       rst3, start3, ack3, rdy3;
    logic [3:0] size3;
    logic       valid3, brp3, last3, done3;
    logic [2:0] top3, bot3;
    logic [1:0] tw3;
    logic [3:0] pass3, state3;

    // LOG2N = 8 instance
    logic       rst8, start8, ack8, rdy8;
    logic [3:0] size8;
    logic       valid8, brp8, last8, done8;
    logic [7:0] top8, bot8;
    logic [6:0] tw8;
    logic [3:0] pass8, state8;

    fft_addr_gen #(.LOG2N(3)) dut3 (
        .Clk(clk), .Reset(rst3), .Start(start3), .Log2Size(size3), .Ack(ack3),
        .out_ready(rdy3), .out_valid(valid3), .i_top(top3), .i_bot(bot3),
        .twiddle(tw3), .pass(pass3), .bitrev_phase(brp3), .last(last3),
        .Done(done3), .state(state3)
    );

    fft_addr_gen #(.LOG2N(8)) dut8 (
        .Clk(clk), .Reset(rst8), .Start(start8), .Log2Size(size8), .Ack(ack8),
        .out_ready(rdy8), .out_valid(valid8), .i_top(top8), .i_bot(bot8),
        .twiddle(tw8), .pass(pass8), .bitrev_phase(brp8), .last(last8),
        .Done(done8), .state(state8)
    );

    // Hand-computed butterfly tuples for an 8-point transform.
    int expTop [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int expBot [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int expTw  [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
    int expPass[12] = '{0, 0, 0, 0,  1, 1, 1, 1,  2, 2, 2, 2};

    int checkCount = 0;
    int passCount  = 0;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse Start for one cycle on the chosen instance, then scramble
    // Log2Size to show it is only sampled at Start.
    task automatic applyStimulus(input bit sel8, input logic [3:0] sz);
        if (sel8) begin
            size8  = sz;
            start8 = 1'b1;
        end else begin
            size3  = sz;
            start3 = 1'b1;
        end
        @(negedge clk);
        start3 = 1'b0;
        start8 = 1'b0;
        size3  = 4'd2;
        size8  = 4'd2;
    endtask

    // Run through a bit-reversal pass, if one is built, with out_ready high.
    task automatic drainBitrev(input bit sel8);
`ifdef FFT_BITREV_EN
        for (int c = 0; c < 600 && (sel8 ? brp8 : brp3); c++) @(negedge clk);
`else
        if (sel8) begin
        end
`endif
    endtask

    task automatic ackPulse(input bit sel8);
        if (sel8) ack8 = 1'b1; else ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;
        ack8 = 1'b0;
    endtask

    // Count accepted PROC transfers on the 8-bit instance until Done.
    task automatic runCount8(input string tag, input int budget,
                             output int xfers, output int lastAt,
                             output int maxBot, output int twSeen);
        xfers  = 0;
        lastAt = -1;
        maxBot = 0;
        twSeen = 0;
        for (int c = 0; c < budget && !done8; c++) begin
            if (valid8 && rdy8 && !brp8) begin
                xfers++;
                if (int'(bot8) > maxBot) maxBot = int'(bot8);
                if (pass8 == 4'd1 && top8 == 8'd1) begin
                    checkOutput({tag, " pass1 k1 twiddle"}, tw8, 64);
                    twSeen++;
                end
                if (last8) lastAt = xfers;
            end
            @(negedge clk);
        end
        checkOutput({tag, " done reached"}, done8, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx, cyc, lastCyc, xfers, lastAt, maxBot, twSeen;

        rst3 = 1'b1; start3 = 1'b0; ack3 = 1'b0; rdy3 = 1'b1; size3 = 4'd3;
        rst8 = 1'b1; start8 = 1'b0; ack8 = 1'b0; rdy8 = 1'b1; size8 = 4'd4;
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        rst8 = 1'b0;

        // Reset state
        checkOutput("reset state",     state3, 1);
        checkOutput("reset out_valid", valid3, 0);
        checkOutput("reset i_top",     top3,   0);
        checkOutput("reset i_bot",     bot3,   1);
        checkOutput("reset twiddle",   tw3,    0);
        checkOutput("reset pass",      pass3,  0);
        checkOutput("reset Done",      done3,  0);
        checkOutput("reset last",      last3,  0);
        checkOutput("reset bitrev",    brp3,   0);
        checkOutput("reset state8",    state8, 1);

        // Full-speed 8-point transform
        applyStimulus(1'b0, 4'd3);
`ifdef FFT_BITREV_EN
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            checkOutput("bitrev phase", brp3, 1);
            if (valid3) begin
                checkOutput($sformatf("bitrev top[%0d]", idx), top3, (idx == 0) ? 1 : 3);
                checkOutput($sformatf("bitrev bot[%0d]", idx), bot3, (idx == 0) ? 4 : 6);
                checkOutput("bitrev twiddle", tw3, 0);
                idx++;
            end
            @(negedge clk);
        end
        checkOutput("bitrev valid count", idx, 2);
`endif
        for (int t = 0; t < 12; t++) begin
            checkOutput($sformatf("run valid[%0d]", t), valid3, 1);
            checkOutput($sformatf("run top[%0d]", t),   top3,   expTop[t]);
            checkOutput($sformatf("run bot[%0d]", t),   bot3,   expBot[t]);
            checkOutput($sformatf("run tw[%0d]", t),    tw3,    expTw[t]);
            checkOutput($sformatf("run pass[%0d]", t),  pass3,  expPass[t]);
            checkOutput($sformatf("run last[%0d]", t),  last3,  (t == 11) ? 1 : 0);
            @(negedge clk);
        end
        checkOutput("run Done after last", done3,  1);
        checkOutput("run state DONE",      state3, 8);
        checkOutput("run valid in DONE",   valid3, 0);
        ackPulse(1'b0);
        checkOutput("ack to IDLE", state3, 1);
        checkOutput("ack clears Done", done3, 0);

        // Stall: out_ready toggles every cycle from the first PROC tuple
        applyStimulus(1'b0, 4'd3);
        drainBitrev(1'b0);
        idx = 0;
        cyc = 0;
        lastCyc = -1;
        while (idx < 12 && cyc < 60) begin
            rdy3 = (cyc % 2 == 0);
            checkOutput($sformatf("stall valid c%0d", cyc), valid3, 1);
            checkOutput($sformatf("stall top c%0d", cyc),   top3,   expTop[idx]);
            checkOutput($sformatf("stall bot c%0d", cyc),   bot3,   expBot[idx]);
            checkOutput($sformatf("stall tw c%0d", cyc),    tw3,    expTw[idx]);
            if (rdy3) begin
                if (idx == 11) lastCyc = cyc;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        rdy3 = 1'b1;
        checkOutput("stall total cycles", lastCyc + 1, 23);
        checkOutput("stall Done", done3, 1);
        ackPulse(1'b0);

        // Reset in the middle of pass 1
        applyStimulus(1'b0, 4'd3);
        drainBitrev(1'b0);
        repeat (5) @(negedge clk);
        checkOutput("midreset pre pass", pass3, 1);
        checkOutput("midreset pre top",  top3,  1);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        checkOutput("midreset state",   state3, 1);
        checkOutput("midreset valid",   valid3, 0);
        checkOutput("midreset top",     top3,   0);
        checkOutput("midreset bot",     bot3,   1);
        checkOutput("midreset twiddle", tw3,    0);
        checkOutput("midreset pass",    pass3,  0);
        checkOutput("midreset last",    last3,  0);
        checkOutput("midreset Done",    done3,  0);
        applyStimulus(1'b0, 4'd3);
        drainBitrev(1'b0);
        checkOutput("restart valid", valid3, 1);
        checkOutput("restart top",   top3,   0);
        checkOutput("restart bot",   bot3,   1);
        checkOutput("restart tw",    tw3,    0);
        for (int c = 0; c < 30 && !done3; c++) @(negedge clk);
        checkOutput("restart Done", done3, 1);
        ackPulse(1'b0);

        // 16-point transform on the 256-point instance
        applyStimulus(1'b1, 4'd4);
        runCount8("size4", 400, xfers, lastAt, maxBot, twSeen);
        checkOutput("size4 transfers", xfers,  32);
        checkOutput("size4 last pos",  lastAt, 32);
        checkOutput("size4 max i_bot", maxBot, 15);
        checkOutput("size4 tw seen",   twSeen, 1);
        ackPulse(1'b1);

        // Log2Size 0 and 9 both clamp to the 256-point maximum
        applyStimulus(1'b1, 4'd0);
        runCount8("size0", 1500, xfers, lastAt, maxBot, twSeen);
        checkOutput("size0 transfers", xfers,  1024);
        checkOutput("size0 last pos",  lastAt, 1024);
        checkOutput("size0 max i_bot", maxBot, 255);
        ackPulse(1'b1);

        applyStimulus(1'b1, 4'd9);
        runCount8("size9", 1500, xfers, lastAt, maxBot, twSeen);
        checkOutput("size9 transfers", xfers,  1024);
        checkOutput("size9 last pos",  lastAt, 1024);

        // Start and Ack together in DONE: back to IDLE, no new transform
        start8 = 1'b1;
        ack8   = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ack8   = 1'b0;
        checkOutput("start+ack state", state8, 1);
        @(negedge clk);
        checkOutput("start+ack stays IDLE", state8, 1);
        checkOutput("start+ack no valid",   valid8, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
